// File: rtl/store_merge_if.sv
// Store request / data-memory port bundle for store_merge.
// The slave modport is the store unit; the master side is CPU control plus memory.
interface store_merge_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] rt_value;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        mem_wready;
  logic        busy;
  logic        done;
  logic        misaligned;

  modport slave (
    input  start, op, addr, rt_value, mem_rdata, mem_rvalid, mem_wready,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy, done, misaligned
  );

  modport master (
    output start, op, addr, rt_value, mem_rdata, mem_rvalid, mem_wready,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy, done, misaligned
  );
endinterface

// File: rtl/store_merge.sv
// SB/SH/SW store unit: SW writes directly, SB/SH read-modify-write the containing word.
// Latency SW 2, SB/SH 3, misaligned 1 cycle(s) from start; each memory wait cycle adds one.
module store_merge (
  input  logic          clk,
  input  logic          reset,
  store_merge_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_e;

  localparam logic [1:0] OP_SB = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged;
  logic        req_misaligned;

  always_comb begin
    req_misaligned = (bus.op == 2'b11)
                   | ((bus.op == OP_SH) & bus.addr[0])
                   | ((bus.op == OP_SW) & (bus.addr[1:0] != 2'b00));
  end

  // wdata_q carries rt_value until the read returns, then the merged word.
  always_comb begin
    merged = bus.mem_rdata;
    if (op_q == OP_SH) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          addr_d  = bus.addr;
          wdata_d = bus.rt_value;
          if (req_misaligned)        state_d = ERR;
          else if (bus.op == OP_SW)  state_d = WR;
          else                       state_d = RD;
        end
      end
      RD: begin
        if (bus.mem_rvalid) begin
          wdata_d = merged;
          state_d = WR;
        end
      end
      WR:      if (bus.mem_wready) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_SB;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_rd_en  = (state_q == RD);
  assign bus.mem_wr_en  = (state_q == WR);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE) || (state_q == ERR);
  assign bus.misaligned = (state_q == ERR);

endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge: bench-side memory responder and hand-computed results.
module tb_store_merge;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  store_merge_if bus ();
  store_merge dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one store from an IDLE negedge and answers the memory port.
  // extra_cyc > 0 pulses a stray SW start in that cycle while busy.
  task automatic do_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] rt,
                          input logic [31:0] mem, input int rd_wait, input int wr_wait,
                          input int extra_cyc,
                          output int done_cyc, output logic mis, output int nrd,
                          output int nwr, output int any_en, output int overlap,
                          output logic [31:0] waddr, output logic [31:0] wdat);
    int rc = 0;
    int wc = 0;
    done_cyc = -1; mis = 1'b0; nrd = 0; nwr = 0; any_en = 0; overlap = 0;
    waddr = '0; wdat = '0;
    bus.start = 1'b1; bus.op = op; bus.addr = a; bus.rt_value = rt; bus.mem_rdata = mem;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (cyc == extra_cyc) begin
        bus.start = 1'b1; bus.op = 2'b10; bus.addr = 32'h300; bus.rt_value = 32'h0BADF00D;
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_wready = 1'b0;
      if (bus.mem_rd_en && bus.mem_wr_en) overlap++;
      if (bus.mem_rd_en || bus.mem_wr_en) any_en++;
      if (bus.mem_rd_en) begin
        rc++;
        if (rc > rd_wait) begin bus.mem_rvalid = 1'b1; nrd++; end
      end
      if (bus.mem_wr_en) begin
        wc++;
        if (wc > wr_wait) begin
          bus.mem_wready = 1'b1; nwr++; waddr = bus.mem_addr; wdat = bus.mem_wdata;
        end
      end
      if (bus.done) begin
        done_cyc = cyc; mis = bus.misaligned;
        break;
      end
    end
    @(negedge clk);
    bus.start = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_wready = 1'b0;
  endtask

  int          dc, nrd, nwr, anyen, ovl;
  logic        mis;
  logic [31:0] wa, wd;
  logic [31:0] sb_exp [4];

  initial begin
    sb_exp[0] = 32'h1122335A; sb_exp[1] = 32'h11225A44;
    sb_exp[2] = 32'h115A3344; sb_exp[3] = 32'h5A223344;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.addr = '0; bus.rt_value = '0;
    bus.mem_rdata = '0; bus.mem_rvalid = 1'b0; bus.mem_wready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_mis", {31'd0, bus.misaligned}, 32'd0);
    check("rst_en", {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 32'd0);
    check("rst_maddr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_store(2'b10, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, dc, mis, nrd, nwr, anyen, ovl, wa, wd);
    check("sw_done_cyc", dc, 2);
    check("sw_mis", {31'd0, mis}, 32'd0);
    check("sw_nrd", nrd, 0);
    check("sw_nwr", nwr, 1);
    check("sw_addr", wa, 32'h100);
    check("sw_wdata", wd, 32'hDEADBEEF);
    check("sw_idle_after", {30'd0, bus.busy, bus.done}, 32'd0);

    do_store(2'b01, 32'h102, 32'h0000ABCD, 32'h11223344, 0, 0, 0, dc, mis, nrd, nwr, anyen, ovl, wa, wd);
    check("sh_done_cyc", dc, 3);
    check("sh_nrd", nrd, 1);
    check("sh_nwr", nwr, 1);
    check("sh_addr", wa, 32'h100);
    check("sh_wdata", wd, 32'hABCD3344);
    check("sh_overlap", ovl, 0);

    for (int i = 0; i < 4; i++) begin
      do_store(2'b00, 32'h200 + i, 32'hFFFFFF5A, 32'h11223344, 0, 0, 0,
               dc, mis, nrd, nwr, anyen, ovl, wa, wd);
      check($sformatf("sb%0d_done_cyc", i), dc, 3);
      check($sformatf("sb%0d_addr", i), wa, 32'h200);
      check($sformatf("sb%0d_wdata", i), wd, sb_exp[i]);
    end

    do_store(2'b01, 32'h101, 32'h1, 32'h0, 0, 0, 0, dc, mis, nrd, nwr, anyen, ovl, wa, wd);
    check("mis_sh_cyc", dc, 1);
    check("mis_sh_flag", {31'd0, mis}, 32'd1);
    check("mis_sh_en", anyen, 0);
    do_store(2'b10, 32'h102, 32'h1, 32'h0, 0, 0, 0, dc, mis, nrd, nwr, anyen, ovl, wa, wd);
    check("mis_sw_cyc", dc, 1);
    check("mis_sw_flag", {31'd0, mis}, 32'd1);
    check("mis_sw_en", anyen, 0);
    do_store(2'b11, 32'h100, 32'h1, 32'h0, 0, 0, 0, dc, mis, nrd, nwr, anyen, ovl, wa, wd);
    check("mis_op3_cyc", dc, 1);
    check("mis_op3_flag", {31'd0, mis}, 32'd1);
    check("mis_op3_en", anyen, 0);

    do_store(2'b01, 32'h100, 32'h00001234, 32'h11223344, 3, 2, 2,
             dc, mis, nrd, nwr, anyen, ovl, wa, wd);
    check("dly_done_cyc", dc, 8);
    check("dly_en_cycles", anyen, 7);
    check("dly_nwr", nwr, 1);
    check("dly_addr", wa, 32'h100);
    check("dly_wdata", wd, 32'h11221234);
    check("dly_overlap", ovl, 0);
    check("dly_not_queued", {31'd0, bus.busy}, 32'd0);

    // Reset while the write is pending with no wready.
    bus.start = 1'b1; bus.op = 2'b10; bus.addr = 32'h104; bus.rt_value = 32'h12345678;
    @(negedge clk);
    bus.start = 1'b0;
    check("rw_wr_en", {31'd0, bus.mem_wr_en}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rw_busy", {31'd0, bus.busy}, 32'd0);
    check("rw_wr_en_low", {31'd0, bus.mem_wr_en}, 32'd0);
    check("rw_no_done", {31'd0, bus.done}, 32'd0);

    do_store(2'b10, 32'h104, 32'hCAFEF00D, 32'h0, 0, 0, 0, dc, mis, nrd, nwr, anyen, ovl, wa, wd);
    check("post_rst_cyc", dc, 2);
    check("post_rst_addr", wa, 32'h104);
    check("post_rst_wdata", wd, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
